score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD score digits (range 2..8).
REQ-002 SHALL have parameter LIVES_INIT, default 3, lives value after reset or clear (range 0..LIVES_MAX).
REQ-003 SHALL have parameter LIVES_MAX, default 9, lives saturation ceiling (range 1..15).
REQ-004 SHALL have parameter BONUS_DIGIT, default 2, digit index whose carry-in awards one extra life (range 1..DIGITS-1).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clear  input  1  synchronous restart to reset values.
REQ-008 SHALL have port add_valid  input  1  add request.
REQ-009 SHALL have port add_points  input  4  points to add, 0..9.
REQ-010 SHALL have port add_ready  output  1  adder can accept a request.
REQ-011 SHALL have port lifedec  input  1  single-cycle lose-a-life strobe.
REQ-012 SHALL have port score  output  4*DIGITS  BCD score; digit 0 in bits [3:0].
REQ-013 SHALL have port lives  output  4  lives remaining.
REQ-014 SHALL have port game_over  output  1  high while lives==0.
REQ-015 SHALL have port overflow  output  1  sticky score-saturated flag.

Function
REQ-016 SHALL implement the adder as FSM states IDLE and ADD, plus a digit index register idx and a one-bit carry register.
REQ-017 SHALL drive add_ready=1 only in IDLE with game_over=0 and overflow=0.
REQ-018 SHALL accept a request in the cycle where add_valid && add_ready: latch the addend (add_points clamped to 9 if >9), set idx=0, go to ADD.
REQ-019 SHALL, each ADD cycle, compute sum=digit[idx]+addend and write digit[idx]=sum-10 with carry=1 if sum>=10, else digit[idx]=sum with carry=0.
REQ-020 SHALL, after each ADD cycle, return to IDLE if carry=0; otherwise set idx=idx+1 and addend=1.
REQ-021 SHALL make the score change visible one cycle after acceptance; each rippled digit adds one cycle; add_ready returns high the cycle after the last ADD cycle.
REQ-022 SHALL treat add_points=0 as a valid request costing one ADD cycle and leaving the score unchanged.
REQ-023 SHALL, on carry out of digit DIGITS-1, set every digit to 9, set overflow=1 and return to IDLE; overflow stays set until reset or clear.
REQ-024 SHALL, in the ADD cycle where idx==BONUS_DIGIT with carry-in, increment lives saturating at LIVES_MAX.
REQ-025 SHALL, on lifedec with lives>0, decrement lives; with lives==0, ignore lifedec.
REQ-026 SHALL, when bonus and lifedec coincide in one cycle, leave lives unchanged; if lives==LIVES_MAX, apply the decrement only.
REQ-027 SHALL drive game_over combinationally as lives==0; once game_over is high, no add is accepted and any in-flight ripple completes.
REQ-028 SHALL give clear priority over all other inputs, abort any in-flight add, and produce the reset state on the next edge.
REQ-029 SHALL ignore add_valid while add_ready=0, without queuing the request.

Reset
REQ-030 SHALL, on reset assertion, immediately force: FSM=IDLE, idx=0, carry=0, score=0, lives=LIVES_INIT, overflow=0, add_ready=1 (0 if LIVES_INIT==0), game_over=(LIVES_INIT==0).
REQ-031 SHALL, when reset is asserted mid-ripple, discard the partial add; digits already written are also zeroed.

Verification (DIGITS=4, LIVES_INIT=3, LIVES_MAX=9, BONUS_DIGIT=2)
REQ-032 SHALL cover: score 0000, add 7 -> score 0007 one cycle after accept; add_ready low 1 cycle.
REQ-033 SHALL cover: score 0095, add 5 -> 0100 after 3 ADD cycles; lives 3->4; add_ready low 3 cycles; add_valid during busy ignored.
REQ-034 SHALL cover: score 9998, add 5 -> score 9999, overflow=1, add_ready stays 0; clear -> 0000, overflow=0, lives=3.
REQ-035 SHALL cover: four lifedec pulses from lives=3 -> 2,1,0; game_over=1 after the third; fourth pulse leaves 0; add_valid is then refused.
REQ-036 SHALL cover: score 0099, add 1 with lifedec in the bonus cycle -> score 0100, lives unchanged at 3.
REQ-037 SHALL cover: score 0999, add 1, reset asserted after the second ADD cycle -> score 0000, lives 3, add_ready 1 immediately.

Source files
------------

// File: rtl/score_keeper.sv
// BCD score keeper: digit-serial ripple adder, lives counter with bonus award
// at a chosen digit, and a sticky saturation flag.
module score_keeper #(
   parameter int DIGITS      = 4,
   parameter int LIVES_INIT  = 3,
   parameter int LIVES_MAX   = 9,
   parameter int BONUS_DIGIT = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  add_valid,
   input  logic [3:0]            add_points,
   output logic                  add_ready,
   input  logic                  lifedec,
   output logic [4*DIGITS-1:0]   score,
   output logic [3:0]            lives,
   output logic                  game_over,
   output logic                  overflow
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [IDX_W-1:0] BONUS_IDX  = IDX_W'(BONUS_DIGIT);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
   localparam logic [3:0]       LIVES_RST  = 4'(LIVES_INIT);
   localparam logic [3:0]       LIVES_CEIL = 4'(LIVES_MAX);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ADD  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [3:0]       addend_q, addend_d;
   logic [3:0]       digit_q [DIGITS];
   logic [3:0]       digit_d [DIGITS];
   logic [3:0]       lives_q, lives_d;
   logic             overflow_q, overflow_d;
   logic             bonus;
   logic [4:0]       dsum;

   // One BCD digit plus addend; bit 4 is the decimal carry out.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] d, input logic [3:0] a);
      logic [4:0] s;
      s = {1'b0, d} + {1'b0, a};
      if (s >= 5'd10) begin
         bcd_digit_add = {1'b1, 4'(s - 5'd10)};
      end else begin
         bcd_digit_add = s;
      end
   endfunction

   function automatic logic [3:0] clamp_points(input logic [3:0] p);
      clamp_points = (p > 4'd9) ? 4'd9 : p;
   endfunction

   // A bonus and a loss in the same cycle cancel, except at the ceiling where
   // the bonus would have been lost to saturation anyway.
   function automatic logic [3:0] lives_update(input logic [3:0] cur,
                                               input logic       gain,
                                               input logic       loss_req);
      logic       loss;
      logic [3:0] res;
      loss = loss_req && (cur != 4'd0);
      res  = cur;
      if (loss && gain) begin
         res = (cur == LIVES_CEIL) ? cur - 4'd1 : cur;
      end else if (loss) begin
         res = cur - 4'd1;
      end else if (gain && (cur < LIVES_CEIL)) begin
         res = cur + 4'd1;
      end
      lives_update = res;
   endfunction

   assign game_over = (lives_q == 4'd0);
   assign add_ready = (state_q == IDLE) && !game_over && !overflow_q;
   assign lives     = lives_q;
   assign overflow  = overflow_q;

   always_comb begin
      score = '0;
      for (int i = 0; i < DIGITS; i++) begin
         score[4*i +: 4] = digit_q[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      carry_d    = carry_q;
      addend_d   = addend_q;
      digit_d    = digit_q;
      overflow_d = overflow_q;
      bonus      = 1'b0;
      dsum       = '0;

      case (state_q)
         IDLE: begin
            if (add_valid && add_ready) begin
               addend_d = clamp_points(add_points);
               idx_d    = '0;
               carry_d  = 1'b0;
               state_d  = ADD;
            end
         end
         ADD: begin
            dsum           = bcd_digit_add(digit_q[idx_q], addend_q);
            digit_d[idx_q] = dsum[3:0];
            carry_d        = dsum[4];
            bonus          = (idx_q == BONUS_IDX) && carry_q;
            if (!dsum[4]) begin
               state_d = IDLE;
            end else if (idx_q == LAST_IDX) begin
               // Carry out of the top digit: pin the score at all nines.
               for (int i = 0; i < DIGITS; i++) begin
                  digit_d[i] = 4'd9;
               end
               overflow_d = 1'b1;
               carry_d    = 1'b0;
               idx_d      = '0;
               state_d    = IDLE;
            end else begin
               idx_d    = idx_q + 1'b1;
               addend_d = 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      lives_d = lives_update(lives_q, bonus, lifedec);

      if (clear) begin
         state_d    = IDLE;
         idx_d      = '0;
         carry_d    = 1'b0;
         addend_d   = '0;
         overflow_d = 1'b0;
         lives_d    = LIVES_RST;
         for (int i = 0; i < DIGITS; i++) begin
            digit_d[i] = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         addend_q   <= '0;
         overflow_q <= 1'b0;
         lives_q    <= LIVES_RST;
         for (int i = 0; i < DIGITS; i++) begin
            digit_q[i] <= 4'd0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         addend_q   <= addend_d;
         overflow_q <= overflow_d;
         lives_q    <= lives_d;
         for (int i = 0; i < DIGITS; i++) begin
            digit_q[i] <= digit_d[i];
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with default parameters; expected values
// are hand-computed BCD scores and lives counts.
module tb_score_keeper;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        add_valid;
   logic [3:0]  add_points;
   logic        add_ready;
   logic        lifedec;
   logic [15:0] score;
   logic [3:0]  lives;
   logic        game_over;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   score_keeper #(
      .DIGITS      (4),
      .LIVES_INIT  (3),
      .LIVES_MAX   (9),
      .BONUS_DIGIT (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .add_valid  (add_valid),
      .add_points (add_points),
      .add_ready  (add_ready),
      .lifedec    (lifedec),
      .score      (score),
      .lives      (lives),
      .game_over  (game_over),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Issue one add and wait for the adder to come back, bounded.
   task automatic add_pts(input logic [3:0] p);
      int n;
      n = 0;
      while (!add_ready && n < 20) begin
         tick();
         n++;
      end
      if (!add_ready) chk("ready_wait_pre", 32'(add_ready), 32'd1);
      add_valid  = 1'b1;
      add_points = p;
      tick();
      add_valid  = 1'b0;
      n = 0;
      while (!add_ready && !overflow && n < 20) begin
         tick();
         n++;
      end
      if (!add_ready && !overflow) chk("ready_wait_post", 32'(add_ready), 32'd1);
   endtask

   initial begin
      clk        = 1'b0;
      reset      = 1'b0;
      clear      = 1'b0;
      add_valid  = 1'b0;
      add_points = 4'd0;
      lifedec    = 1'b0;

      #1 reset = 1'b1;
      #1;
      chk("rst_score",    32'(score),     32'h0000);
      chk("rst_lives",    32'(lives),     32'd3);
      chk("rst_ready",    32'(add_ready), 32'd1);
      chk("rst_gameover", 32'(game_over), 32'd0);
      chk("rst_overflow", 32'(overflow),  32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Single-digit add: visible one cycle after accept.
      add_valid  = 1'b1;
      add_points = 4'd7;
      tick();
      add_valid = 1'b0;
      chk("add7_busy_ready", 32'(add_ready), 32'd0);
      chk("add7_busy_score", 32'(score),     32'h0000);
      tick();
      chk("add7_score", 32'(score),     32'h0007);
      chk("add7_ready", 32'(add_ready), 32'd1);

      // Out-of-range points clamp to 9.
      add_pts(4'd12);
      chk("clamp_score", 32'(score), 32'h0016);
      add_pts(4'd0);
      chk("zero_add_score", 32'(score), 32'h0016);

      // 0095 + 5 ripples three digits and awards a life.
      do_clear();
      for (int i = 0; i < 10; i++) add_pts(4'd9);
      add_pts(4'd5);
      chk("pre95_score", 32'(score), 32'h0095);
      add_valid  = 1'b1;
      add_points = 4'd5;
      tick();
      add_points = 4'd9;
      chk("rip_c0_ready", 32'(add_ready), 32'd0);
      tick();
      chk("rip_c1_ready", 32'(add_ready), 32'd0);
      chk("rip_c1_score", 32'(score),     32'h0090);
      tick();
      add_valid = 1'b0;
      chk("rip_c2_ready", 32'(add_ready), 32'd0);
      chk("rip_c2_score", 32'(score),     32'h0000);
      tick();
      chk("rip_score", 32'(score),     32'h0100);
      chk("rip_lives", 32'(lives),     32'd4);
      chk("rip_ready", 32'(add_ready), 32'd1);
      tick();
      chk("busy_ignored_score", 32'(score), 32'h0100);

      // Lifedec coinciding with the bonus cycle leaves lives unchanged.
      do_clear();
      for (int i = 0; i < 11; i++) add_pts(4'd9);
      chk("pre99_score", 32'(score), 32'h0099);
      add_valid  = 1'b1;
      add_points = 4'd1;
      tick();
      add_valid = 1'b0;
      tick();
      tick();
      lifedec = 1'b1;
      tick();
      lifedec = 1'b0;
      chk("coinc_score", 32'(score), 32'h0100);
      chk("coinc_lives", 32'(lives), 32'd3);

      // Losing all lives, then one more, then a refused add.
      do_clear();
      lifedec = 1'b1; tick(); lifedec = 1'b0;
      chk("dec1_lives", 32'(lives), 32'd2);
      lifedec = 1'b1; tick(); lifedec = 1'b0;
      chk("dec2_lives", 32'(lives), 32'd1);
      chk("dec2_gameover", 32'(game_over), 32'd0);
      lifedec = 1'b1; tick(); lifedec = 1'b0;
      chk("dec3_lives", 32'(lives), 32'd0);
      chk("dec3_gameover", 32'(game_over), 32'd1);
      lifedec = 1'b1; tick(); lifedec = 1'b0;
      chk("dec4_lives", 32'(lives), 32'd0);
      chk("go_ready", 32'(add_ready), 32'd0);
      add_valid  = 1'b1;
      add_points = 4'd5;
      tick();
      tick();
      add_valid = 1'b0;
      chk("go_refused_score", 32'(score), 32'h0000);

      // Asynchronous reset mid-ripple discards the partial add.
      do_clear();
      for (int i = 0; i < 111; i++) add_pts(4'd9);
      chk("pre999_score", 32'(score), 32'h0999);
      add_valid  = 1'b1;
      add_points = 4'd1;
      tick();
      add_valid = 1'b0;
      tick();
      chk("mid_c1_score", 32'(score), 32'h0990);
      tick();
      chk("mid_c2_score", 32'(score), 32'h0900);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_score", 32'(score),     32'h0000);
      chk("mid_rst_lives", 32'(lives),     32'd3);
      chk("mid_rst_ready", 32'(add_ready), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_score", 32'(score),     32'h0000);
      chk("post_rst_ready", 32'(add_ready), 32'd1);

      // Saturation at 9999 and recovery by clear.
      for (int i = 0; i < 1110; i++) add_pts(4'd9);
      add_pts(4'd8);
      chk("pre9998_score", 32'(score),    32'h9998);
      chk("pre9998_ovf",   32'(overflow), 32'd0);
      add_valid  = 1'b1;
      add_points = 4'd5;
      tick();
      add_valid = 1'b0;
      tick();
      chk("ovf_c1_score", 32'(score), 32'h9993);
      tick();
      tick();
      chk("ovf_c3_score", 32'(score), 32'h9003);
      tick();
      chk("ovf_score", 32'(score),     32'h9999);
      chk("ovf_flag",  32'(overflow),  32'd1);
      chk("ovf_ready", 32'(add_ready), 32'd0);
      add_valid = 1'b1;
      tick();
      tick();
      add_valid = 1'b0;
      chk("ovf_sticky", 32'(overflow),  32'd1);
      chk("ovf_hold",   32'(score),     32'h9999);
      chk("ovf_ready2", 32'(add_ready), 32'd0);
      do_clear();
      chk("clr_score", 32'(score),     32'h0000);
      chk("clr_ovf",   32'(overflow),  32'd0);
      chk("clr_lives", 32'(lives),     32'd3);
      chk("clr_ready", 32'(add_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
